// File: rtl/mmio_gpio_bank_if.sv
// -----------------------------------------------------------------------------
// mmio_gpio_bank_if
//   Bus bundle between the core's address/store-data path, data memory and
//   the memory-mapped GPIO bank.
//
//   we        core -> bank   store strobe (MemWrite)
//   addr      core -> bank   ALU result address
//   wdata     core -> bank   store data
//   mem_rdata mem  -> bank   read data from data memory
//   rdata     bank -> core   load data to the result mux
//   hit       bank -> core   addr falls inside the bank window
//   mem_we    bank -> mem    write enable forwarded to data memory
// -----------------------------------------------------------------------------
interface mmio_gpio_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;
    logic              hit;
    logic              mem_we;

    modport master (
        output we, addr, wdata, mem_rdata,
        input  rdata, hit, mem_we
    );

    modport slave (
        input  we, addr, wdata, mem_rdata,
        output rdata, hit, mem_we
    );
endinterface

// File: rtl/mmio_gpio_bank.sv
// -----------------------------------------------------------------------------
// mmio_gpio_bank
//   N_CH memory-mapped parallel I/O channels, DATA_W bits each. Every channel
//   has four registers at BASE_ADDR + 4*ch + reg:
//     0 OUT  (r/w, drives pin_out)   1 IN   (r/o, debounced pin_in)
//     2 EDGE (r / write-1-to-clear)  3 MASK (r/w, enables EDGE into irq)
//   Inputs pass a 2-flop synchroniser and a per-channel debouncer before
//   reaching IN; 0->1 transitions of IN are latched in EDGE.
//
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   bus      slave side of the core / data-memory bus (see mmio_gpio_bank_if)
//   pin_in   external inputs, channel c at [c*DATA_W +: DATA_W]
//   pin_out  external outputs, channel c at [c*DATA_W +: DATA_W]
//   irq      OR of EDGE & MASK over all channels
// -----------------------------------------------------------------------------
module mmio_gpio_bank #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int N_CH       = 2,
    parameter int BASE_ADDR  = 'hF0,
    parameter int DEB_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mmio_gpio_bank_if.slave        bus,
    input  logic [N_CH*DATA_W-1:0] pin_in,
    output logic [N_CH*DATA_W-1:0] pin_out,
    output logic                   irq
);
    // With DEB_CYCLES = 0 the counter still needs one bit to exist.
    localparam int CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Window bounds carry one extra bit so a window ending at the top of the
    // address space does not wrap.
    localparam logic [ADDR_W:0]  WIN_LO  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]  WIN_HI  = (ADDR_W+1)'(BASE_ADDR + 4*N_CH);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0] offset;
    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        reg_sel;
    logic              hit;
    logic              wr_bank;

    assign offset  = bus.addr - ADDR_W'(BASE_ADDR);
    assign ch_sel  = CH_W'(offset >> 2);
    assign reg_sel = offset[1:0];
    assign hit     = ({1'b0, bus.addr} >= WIN_LO) && ({1'b0, bus.addr} < WIN_HI);
    assign wr_bank = bus.we && hit;

    assign bus.hit    = hit;
    assign bus.mem_we = bus.we && !hit;

    // ---------------- per-channel state ----------------
    logic [DATA_W-1:0] out_q  [N_CH];
    logic [DATA_W-1:0] in_q   [N_CH];
    logic [DATA_W-1:0] edge_q [N_CH];
    logic [DATA_W-1:0] mask_q [N_CH];
    logic [DATA_W-1:0] s1_q   [N_CH];
    logic [DATA_W-1:0] s2_q   [N_CH];
    logic [DATA_W-1:0] cand_q [N_CH];
    logic [CNT_W-1:0]  cnt_q  [N_CH];

    logic [DATA_W-1:0] edge_nxt [N_CH];
    logic [N_CH-1:0]   accept;
    logic [DATA_W-1:0] rd_bank;

    // Debouncer accepts the candidate once it has matched the synchronised
    // input for DEB_CYCLES consecutive edges. On the accepting edge the
    // rising bits are set in EDGE; the set term is ORed in after the W1C
    // mask so a simultaneous clear never loses a new edge.
    always_comb begin
        // NOTE: every output of this block gets a default before any
        // conditional logic, so no path can leave a latch behind.
        accept = '0;
        for (int c = 0; c < N_CH; c++) begin
            accept[c]   = (s2_q[c] == cand_q[c]) && !(cnt_q[c] < DEB_MAX);
            edge_nxt[c] = (edge_q[c]
                           & ~((wr_bank && ch_sel == CH_W'(c) && reg_sel == REG_EDGE)
                               ? bus.wdata : '0))
                          | (accept[c] ? (cand_q[c] & ~in_q[c]) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these arrays are small flop banks, not RAM, so every
            // entry is cleared; reset may arrive mid-debounce.
            for (int c = 0; c < N_CH; c++) begin
                out_q[c]  <= '0;
                in_q[c]   <= '0;
                edge_q[c] <= '0;
                mask_q[c] <= '0;
                s1_q[c]   <= '0;
                s2_q[c]   <= '0;
                cand_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep s1 -> s2 -> cand a true
            // pipeline; blocking ones would collapse it into one stage.
            for (int c = 0; c < N_CH; c++) begin
                s1_q[c] <= pin_in[c*DATA_W +: DATA_W];
                s2_q[c] <= s1_q[c];

                if (s2_q[c] != cand_q[c]) begin
                    cand_q[c] <= s2_q[c];
                    cnt_q[c]  <= '0;
                end else if (cnt_q[c] < DEB_MAX) begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end else begin
                    in_q[c] <= cand_q[c];
                end

                edge_q[c] <= edge_nxt[c];

                if (wr_bank && ch_sel == CH_W'(c)) begin
                    if (reg_sel == REG_OUT)  out_q[c]  <= bus.wdata;
                    if (reg_sel == REG_MASK) mask_q[c] <= bus.wdata;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        pin_out = '0;
        irq     = 1'b0;
        rd_bank = '0;
        for (int c = 0; c < N_CH; c++) begin
            pin_out[c*DATA_W +: DATA_W] = out_q[c];
            irq = irq | (|(edge_q[c] & mask_q[c]));
            if (ch_sel == CH_W'(c)) begin
                case (reg_sel)
                    REG_OUT:  rd_bank = out_q[c];
                    REG_IN:   rd_bank = in_q[c];
                    REG_EDGE: rd_bank = edge_q[c];
                    default:  rd_bank = mask_q[c];
                endcase
            end
        end
    end

    assign bus.rdata = hit ? rd_bank : bus.mem_rdata;

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_gpio_bank
//   Directed scenarios followed by random traffic. The reference model keeps
//   the full history of sampled pin values per channel: IN takes value v on
//   edge n when the pin was sampled as v on each of edges n-DEB-3 .. n-2.
//   A reset on edge r is modelled as zero samples on edges r-2 .. r.
// -----------------------------------------------------------------------------
module tb_mmio_gpio_bank;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int N_CH   = 2;
    localparam int BASE   = 'hF0;
    localparam int DEB    = 4;
    localparam int HMAX   = 1024;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH*DATA_W-1:0] pin_in;
    logic [N_CH*DATA_W-1:0] pin_out;
    logic                   irq;

    mmio_gpio_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mmio_gpio_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH),
        .BASE_ADDR(BASE), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pin_in(pin_in), .pin_out(pin_out), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int         n_edge = 16;
    logic [7:0] hist   [N_CH][HMAX];
    logic [7:0] m_out  [N_CH];
    logic [7:0] m_in   [N_CH];
    logic [7:0] m_edge [N_CH];
    logic [7:0] m_mask [N_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int hidx(input int j);
        return j % HMAX;
    endfunction

    function automatic logic in_window(input logic [7:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + 4*N_CH);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] mrd);
        int off;
        if (!in_window(a)) return mrd;
        off = int'(a) - BASE;
        case (off % 4)
            0:       return m_out[off/4];
            1:       return m_in[off/4];
            2:       return m_edge[off/4];
            default: return m_mask[off/4];
        endcase
    endfunction

    function automatic logic [15:0] model_pins();
        logic [15:0] p = '0;
        for (int c = 0; c < N_CH; c++) p[c*8 +: 8] = m_out[c];
        return p;
    endfunction

    function automatic logic model_irq();
        logic r = 1'b0;
        for (int c = 0; c < N_CH; c++) r = r | (|(m_edge[c] & m_mask[c]));
        return r;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [7:0] a,
                              input logic [7:0] wd, input logic [15:0] pin);
        logic [7:0] v, clr, rise;
        logic       stable, sel;
        int         off;
        n_edge++;
        off = int'(a) - BASE;
        for (int c = 0; c < N_CH; c++) begin
            if (r) begin
                hist[c][hidx(n_edge)]   = '0;
                hist[c][hidx(n_edge-1)] = '0;
                hist[c][hidx(n_edge-2)] = '0;
                m_out[c] = '0; m_in[c] = '0; m_edge[c] = '0; m_mask[c] = '0;
            end else begin
                hist[c][hidx(n_edge)] = pin[c*8 +: 8];
                v      = hist[c][hidx(n_edge-2)];
                stable = 1'b1;
                for (int j = n_edge - DEB - 3; j <= n_edge - 2; j++)
                    if (hist[c][hidx(j)] !== v) stable = 1'b0;
                sel  = w && in_window(a) && (off / 4 == c);
                clr  = (sel && off % 4 == 2) ? wd : 8'h00;
                rise = stable ? (v & ~m_in[c]) : 8'h00;
                m_edge[c] = (m_edge[c] & ~clr) | rise;
                if (stable) m_in[c] = v;
                if (sel && off % 4 == 0) m_out[c]  = wd;
                if (sel && off % 4 == 3) m_mask[c] = wd;
            end
        end
    endtask

    // One clock: drive, compare every output with the model, take the edge.
    task automatic cycle(input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] mrd, input logic [15:0] pin);
        rst = r; bus.we = w; bus.addr = a; bus.wdata = wd; bus.mem_rdata = mrd; pin_in = pin;
        #1;
        check("hit",     bus.hit,    in_window(a));
        check("mem_we",  bus.mem_we, w && !in_window(a));
        check("rdata",   bus.rdata,  model_read(a, mrd));
        check("pin_out", pin_out,    model_pins());
        check("irq",     irq,        model_irq());
        @(posedge clk);
        model_edge(r, w, a, wd, pin);
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] mrd,
                        input logic [7:0] exp);
        rst = 1'b0; bus.we = 1'b0; bus.addr = a; bus.mem_rdata = mrd;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic hold(input int n, input logic [15:0] pin);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'hF1, 8'h00, 8'h00, pin);
    endtask

    initial begin
        logic [15:0] pv;
        logic [7:0]  a;
        for (int c = 0; c < N_CH; c++)
            for (int j = 0; j < HMAX; j++) hist[c][j] = '0;

        // Reset: state is unknown before the first edge, so no compare yet.
        rst = 1'b1; bus.we = 1'b0; bus.addr = 8'h10; bus.wdata = '0;
        bus.mem_rdata = '0; pin_in = '0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 8'h10, 8'h00, 16'h0000);
        @(negedge clk);
        check("rst_pin_out", pin_out, 16'h0000);
        check("rst_irq", irq, 1'b0);
        peek("rst_passthru", 8'h10, 8'h5A, 8'h5A);

        // Write OUT of channel 1.
        cycle(1'b0, 1'b1, 8'hF4, 8'hA5, 8'h00, 16'h0000);
        check("wr_pin_out", pin_out[15:8], 8'hA5);
        peek("rd_f4", 8'hF4, 8'h00, 8'hA5);

        // Store outside the window goes to memory only.
        cycle(1'b0, 1'b1, 8'h10, 8'h77, 8'h00, 16'h0000);
        peek("pass_rd", 8'h10, 8'h3C, 8'h3C);
        check("pass_bank", pin_out, 16'hA500);

        // Debounce: held change lands after the 8th edge.
        hold(7, 16'h0081);
        peek("deb_e7", 8'hF1, 8'h00, 8'h00);
        hold(1, 16'h0081);
        peek("deb_e8", 8'hF1, 8'h00, 8'h81);

        // Glitch of 5 cycles is rejected.
        hold(10, 16'h0000);
        hold(5,  16'h0081);
        hold(10, 16'h0000);
        peek("glitch", 8'hF1, 8'h00, 8'h00);

        // Edge capture, irq, W1C, falling edge ignored.
        cycle(1'b0, 1'b1, 8'hF2, 8'hFF, 8'h00, 16'h0000);
        peek("edge_clr_all", 8'hF2, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 8'hF3, 8'h01, 8'h00, 16'h0000);
        hold(8, 16'h0001);
        peek("edge_set", 8'hF2, 8'h00, 8'h01);
        check("irq_set", irq, 1'b1);
        cycle(1'b0, 1'b1, 8'hF2, 8'h01, 8'h00, 16'h0001);
        peek("edge_w1c", 8'hF2, 8'h00, 8'h00);
        check("irq_clr", irq, 1'b0);
        hold(10, 16'h0000);
        peek("fall_no_edge", 8'hF2, 8'h00, 8'h00);

        // W1C on the same edge as a new rise: set wins.
        hold(7, 16'h0001);
        cycle(1'b0, 1'b1, 8'hF2, 8'h01, 8'h00, 16'h0001);
        peek("w1c_vs_set", 8'hF2, 8'h00, 8'h01);
        check("w1c_vs_set_irq", irq, 1'b1);

        // Reset on the 5th edge of a debounce restarts it.
        pv = 16'h5A01;
        hold(4, pv);
        cycle(1'b1, 1'b0, 8'hF5, 8'h00, 8'h00, pv);
        check("rst_mid_pins", pin_out, 16'h0000);
        check("rst_mid_irq", irq, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 8'hF5, 8'h00, 8'h00, pv);
        peek("rst_mid_e7", 8'hF5, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 8'hF5, 8'h00, 8'h00, pv);
        peek("rst_mid_e8", 8'hF5, 8'h00, 8'h5A);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(7) == 0) pv[c*8 +: 8] = 8'($urandom);
            a = ($urandom_range(1) == 0) ? 8'(BASE + $urandom_range(4*N_CH-1)) : 8'($urandom);
            cycle(($urandom_range(149) == 0), 1'($urandom), a,
                  8'($urandom), 8'($urandom), pv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
- Parametrised memory-mapped parallel I/O bank that sits between the ALU address/store-data path and data memory of the single-cycle core.
- Generalises the single-port parallel input/output pair to N_CH channels, each DATA_W bits wide.
- Adds a 2-flop input synchroniser, a per-channel debouncer, rising-edge capture with write-1-to-clear, and a masked interrupt output.
- Decodes its own address window and gates data-memory writes and read data accordingly.

Parameters:
- DATA_W, 8, width of one channel and of the data bus
- ADDR_W, 8, address bus width
- N_CH, 2, number of channels (1..16)
- BASE_ADDR, 8'hF0, first address of the window; must be aligned to 4*N_CH
- DEB_CYCLES, 4, stability cycles required before an input value is accepted (0..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- we  in  1  store strobe from control (MemWrite)
- addr  in  ADDR_W  ALU result address
- wdata  in  DATA_W  store data (rd2)
- mem_rdata  in  DATA_W  read data from data memory
- rdata  out  DATA_W  load data to the result mux
- hit  out  1  addr is inside the window
- mem_we  out  1  write enable forwarded to data memory
- pin_in  in  N_CH*DATA_W  external inputs; channel c occupies bits [c*DATA_W +: DATA_W]
- pin_out  out  N_CH*DATA_W  external outputs
- irq  out  1  interrupt request

Behaviour:
- Window: BASE_ADDR .. BASE_ADDR+4*N_CH-1. ch = (addr-BASE_ADDR)>>2; reg = (addr-BASE_ADDR)[1:0].
- Register map per channel:
  - reg 0: OUT, read/write.
  - reg 1: IN, read-only; writes are ignored.
  - reg 2: EDGE, read / write-1-to-clear.
  - reg 3: MASK, read/write.
- Combinational outputs:
  - hit = (addr in window).
  - mem_we = we & ~hit.
  - rdata = selected register when hit, else mem_rdata. No read latency.
- Writes with we & hit take effect at the next rising clk edge. pin_out reflects OUT directly, so the new value appears right after that edge.
- Input path, per channel, evaluated every edge:
  - Synchroniser: s1 <= pin; s2 <= s1.
  - Debouncer, with candidate register cand and counter cnt of width clog2(DEB_CYCLES+1), saturating:
    - if s2 != cand: cand <= s2, cnt <= 0;
    - else if cnt < DEB_CYCLES: cnt <= cnt+1;
    - else IN <= cand.
  - Net effect: a pin change that is stable from before edge k is visible in IN after edge k+DEB_CYCLES+3, i.e. DEB_CYCLES+4 edges total. Any glitch shorter than that never reaches IN.
- Edge capture:
  - When IN loads a new value, EDGE |= new & ~old (0->1 transitions only).
  - If a W1C write hits the same bit in the same cycle as a new rising edge, set wins and the bit stays 1.
  - Falling transitions do not affect EDGE.
- irq = OR over all channels and bits of (EDGE & MASK). Combinational from registers, so it asserts the cycle after the capturing edge.
- Reset (synchronous, any time, including mid-debounce):
  - OUT, IN, EDGE, MASK, cand, cnt, s1 and s2 are all cleared to 0.
  - pin_out=0 and irq=0 after the reset edge.
  - No edge is captured on the first IN update after reset unless the accepted value has bits set.
- Addresses inside the window never write data memory. Addresses outside the window never modify bank registers.

Test Plan:
- Reset and write, N_CH=2, BASE_ADDR=F0:
  - Assert rst for 1 edge → pin_out=0, irq=0, rdata=mem_rdata for addr=10.
  - Then we=1, addr=F4, wdata=A5 → after 1 edge pin_out[15:8]=A5, mem_we=0; reading F4 gives A5.
- Passthrough: we=1, addr=10 → mem_we=1, hit=0, bank unchanged; addr=10 with mem_rdata=3C → rdata=3C.
- Debounce, DEB_CYCLES=4:
  - pin_in[7:0] changes 00→81 and is held → reading F1 gives 00 through edge 7 and 81 after edge 8.
  - A 81 pulse lasting 5 cycles → F1 stays 00.
- Edge and irq:
  - Write MASK F3=01, then pin_in[7:0]=01 → EDGE F2=01, irq=1 one cycle after IN updates.
  - Write F2=01 → EDGE=00, irq=0.
  - Pin 01→00 → EDGE stays 00.
- Simultaneous clear and set: W1C F2=01 on the same edge IN rises 00→01 → EDGE=01 and irq stays 1.
- Reset mid-debounce: pin_in changes, then rst is asserted at edge 5 → IN=00 and cnt restarts, so the new value is visible only DEB_CYCLES+4 edges after rst is released.
